pe_load_seq: RTL and testbench

//  Sequencer for one systolic-array PE row. It drives the select and data inputs of the PE input

---
 rtl/pe_load_if.sv | 28 ++
 rtl/pe_load_seq.sv | 122 ++++++++++++
 tb/tb_pe_load_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pe_load_if.sv
// Handshake and demux bus between the input FIFO, the load sequencer and the PE row demux.
interface pe_load_if #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
);
  logic              start;
  logic [CWIDTH-1:0] k_len;
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              dmx_s;
  logic [DWIDTH-1:0] dmx_d;
  logic              dmx_stb;
  logic              busy;
  logic              done;

  // Controller / upstream side: issues jobs and data, observes the demux bus.
  modport master (
    output start, k_len, in_valid, in_data,
    input  in_ready, dmx_s, dmx_d, dmx_stb, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, k_len, in_valid, in_data,
    output in_ready, dmx_s, dmx_d, dmx_stb, busy, done
  );
endinterface

// File: rtl/pe_load_seq.sv
// Load sequencer for one systolic PE row: per job, ROWS weight beats to the
// weight path, k_len activation beats to the compute path, a drain window
// covering the row skew, then a one-cycle done pulse.
module pe_load_seq #(
  parameter int DWIDTH = 8,
  parameter int ROWS   = 4,
  parameter int CWIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  pe_load_if.slave  bus
);

  // Counter must hold both the activation count and the drain length.
  localparam int CNTW = (CWIDTH > $clog2(2*ROWS)) ? CWIDTH : $clog2(2*ROWS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_ACT    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNTW-1:0] W_LAST = CNTW'(ROWS - 1);
  localparam logic [CNTW-1:0] D_LAST = CNTW'(2*ROWS - 2);

  logic [2:0]        state;
  logic [2:0]        nxt_state;
  logic [CNTW-1:0]   cnt;
  logic [CNTW-1:0]   nxt_cnt;
  logic [CWIDTH-1:0] klen_r;
  logic [CNTW-1:0]   a_last;
  logic              in_ready;
  logic              accept;

  // Ready depends on state only so upstream may wait for ready before raising valid.
  assign in_ready     = (state == S_LOAD_W) || (state == S_ACT);
  assign accept       = bus.in_valid && in_ready;
  // klen_r is non-zero whenever ACT is entered, so this never wraps where it is used.
  assign a_last       = CNTW'(klen_r) - CNTW'(1);
  assign bus.in_ready = in_ready;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);

  // Next-state and counter logic; counters only advance on accepted beats in the load phases.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          nxt_state = S_LOAD_W;
          nxt_cnt   = '0;
        end
      end
      S_LOAD_W: begin
        if (accept) begin
          if (cnt == W_LAST) begin
            nxt_cnt   = '0;
            nxt_state = (klen_r != '0) ? S_ACT : S_DRAIN;
          end else begin
            nxt_cnt = cnt + CNTW'(1);
          end
        end
      end
      S_ACT: begin
        if (accept) begin
          if (cnt == a_last) begin
            nxt_cnt   = '0;
            nxt_state = S_DRAIN;
          end else begin
            nxt_cnt = cnt + CNTW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt == D_LAST) begin
          nxt_cnt   = '0;
          nxt_state = S_DONE;
        end else begin
          nxt_cnt = cnt + CNTW'(1);
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // State, counter and job-length registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      klen_r <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (state == S_IDLE && bus.start) klen_r <= bus.k_len;
    end
  end

  // Registered demux drive: one-cycle latency from accept; select holds between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dmx_d   <= '0;
      bus.dmx_s   <= 1'b0;
      bus.dmx_stb <= 1'b0;
    end else if (accept) begin
      bus.dmx_d   <= bus.in_data;
      bus.dmx_s   <= (state == S_LOAD_W);
      bus.dmx_stb <= 1'b1;
    end else begin
      bus.dmx_d   <= '0;
      bus.dmx_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_load_seq.sv
// Directed bench for pe_load_seq (ROWS=4, DWIDTH=8, CWIDTH=16).
module tb_pe_load_seq;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int ROWS = 4;
  localparam int DRAIN_CYC = 2*ROWS - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic last_s   = 1'b0;

  pe_load_if #(.DWIDTH(DW), .CWIDTH(CW)) bus ();

  pe_load_seq #(.DWIDTH(DW), .ROWS(ROWS), .CWIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_s"},     32'(bus.dmx_s),    32'd0);
    chk({tag, "_d"},     32'(bus.dmx_d),    32'd0);
    chk({tag, "_stb"},   32'(bus.dmx_stb),  32'd0);
    chk({tag, "_busy"},  32'(bus.busy),     32'd0);
    chk({tag, "_done"},  32'(bus.done),     32'd0);
  endtask

  // One complete job: ROWS weight beats, kl activation beats, drain, done.
  // spurious=1 pulses start (with a different k_len) during ACT and DRAIN.
  task automatic run_job(input int kl, input bit bubbles, input bit spurious, input int first_data);
    int  total;
    int  acc;
    int  cyc;
    int  d;
    bit  v;
    logic exp_s;
    total = ROWS + kl;
    acc   = 0;
    cyc   = 0;
    d     = first_data;
    bus.k_len = CW'(kl);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.k_len = CW'(9);
    chk("job_busy", 32'(bus.busy), 32'd1);
    while (acc < total) begin
      v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = DW'(d);
      bus.start    = spurious && (acc == ROWS + 1);
      chk("load_ready", 32'(bus.in_ready), 32'd1);
      exp_s = (acc < ROWS);
      tick();
      bus.start = 1'b0;
      if (v) begin
        chk("beat_stb", 32'(bus.dmx_stb), 32'd1);
        chk("beat_d",   32'(bus.dmx_d),   32'(d));
        chk("beat_s",   32'(bus.dmx_s),   32'(exp_s));
        last_s = exp_s;
        acc++;
        d++;
      end else begin
        chk("gap_stb", 32'(bus.dmx_stb), 32'd0);
        chk("gap_d",   32'(bus.dmx_d),   32'd0);
        chk("gap_s",   32'(bus.dmx_s),   32'(last_s));
      end
      cyc++;
      if (cyc > 200) begin
        chk("beat_timeout", 32'(acc), 32'(total));
        break;
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < DRAIN_CYC; i++) begin
      chk("drain_ready", 32'(bus.in_ready), 32'd0);
      chk("drain_busy",  32'(bus.busy),     32'd1);
      chk("drain_done",  32'(bus.done),     32'd0);
      bus.start    = spurious && (i == 2);
      bus.in_valid = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      chk("drain_stb", 32'(bus.dmx_stb), 32'd0);
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy",  32'(bus.busy), 32'd1);
    chk("done_s",     32'(bus.dmx_s), 32'(kl == 0 ? 1 : 0));
    tick();
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ready", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    #2;
    chk_all_zero("rst_hold");
    tick();
    #2 rst = 1'b0;
    tick();
    chk_all_zero("rst_idle");

    // Stray valid/start-free cycle in IDLE has no effect
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    tick();
    bus.in_valid = 1'b0;
    chk("idle_valid_stb", 32'(bus.dmx_stb), 32'd0);
    chk("idle_valid_busy", 32'(bus.busy), 32'd0);

    // Basic job, k_len=3, data 1..7
    run_job(3, 1'b0, 1'b0, 1);
    $display("job basic k_len=3 done checks=%0d", checks);

    // k_len=0: weights only
    run_job(0, 1'b0, 1'b0, 16);
    $display("job k_len=0 done checks=%0d", checks);

    // Bubbles on in_valid
    run_job(3, 1'b1, 1'b0, 1);
    $display("job bubbles k_len=3 done checks=%0d", checks);

    // Spurious starts, then a back-to-back job right after DONE
    run_job(3, 1'b0, 1'b1, 32);
    run_job(1, 1'b0, 1'b0, 48);
    $display("job spurious-start + back-to-back done checks=%0d", checks);

    // Reset mid-ACT after one activation beat
    bus.k_len = CW'(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < ROWS + 1; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(8'h60 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_stb",  32'(bus.dmx_stb), 32'd1);
    chk("pre_rst_busy", 32'(bus.busy),    32'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    #2 rst = 1'b0;
    last_s = 1'b0;
    tick();
    chk_all_zero("post_rst");
    run_job(2, 1'b0, 1'b0, 100);
    $display("job after mid-ACT reset k_len=2 done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
